// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
//   Scans a 4x4 matrix keypad, debounces presses and releases over whole
//   scans, decodes each accepted key to a hex code and shifts it into a
//   16-bit entry register that feeds the 4-digit display.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset (overrides clr)
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   clr        synchronous clear of the entry register
//   col[3:0]   column drive, active-low, exactly one bit low
//   data[15:0] entry register, newest digit in data[3:0]
//   key_code   code of the most recently accepted key
//   key_valid  one-cycle pulse per accepted key
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; the
// consumer must take key_code/data in the cycle key_valid is high.
//
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, every 16
// further consecutive scans of that same key re-run the accept action.
// Without it, exactly one accept happens per press/release cycle.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [15:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      acc;        // pressed rows of columns 0..2, bit = c*4+r
    logic             last_dwell;
    logic             scan_done;
    logic [15:0]      scan;
    logic             single;
    logic [3:0]       pos;
    logic [3:0]       code;

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [3:0]       cand, cand_n;
    logic             accept;
    logic [15:0]      data_n;
`ifdef KEYPAD_REPEAT_EN
    logic [3:0]       rep, rep_n;
`endif

    function automatic logic [3:0] key_lookup(input logic [3:0] p);
        // p = {column, row}
        case (p)
            4'h0: key_lookup = 4'h1;  4'h1: key_lookup = 4'h4;
            4'h2: key_lookup = 4'h7;  4'h3: key_lookup = 4'hE;
            4'h4: key_lookup = 4'h2;  4'h5: key_lookup = 4'h5;
            4'h6: key_lookup = 4'h8;  4'h7: key_lookup = 4'h0;
            4'h8: key_lookup = 4'h3;  4'h9: key_lookup = 4'h6;
            4'hA: key_lookup = 4'h9;  4'hB: key_lookup = 4'hF;
            4'hC: key_lookup = 4'hA;  4'hD: key_lookup = 4'hB;
            4'hE: key_lookup = 4'hC;  default: key_lookup = 4'hD;
        endcase
    endfunction

    assign col        = ~(4'b0001 << col_idx);
    assign last_dwell = (div_cnt == DIV_LAST);
    assign scan_done  = last_dwell && (col_idx == 2'd3);
    // Column 3 is folded in straight from the synchronizer so the FSM
    // acts on the same edge as the final sample.
    assign scan       = {~row_s2, acc};
    assign single     = (scan != 16'h0000) && ((scan & (scan - 16'd1)) == 16'h0000);
    assign code       = key_lookup(pos);

    always_comb begin
        pos = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (scan[i]) pos = 4'(i);
        end
    end

    // Scanner: synchronizer, dwell counter, column counter, row capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            div_cnt <= '0;
            col_idx <= 2'd0;
            acc     <= 12'h000;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (last_dwell) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                case (col_idx)
                    2'd0:    acc[3:0]  <= ~row_s2;
                    2'd1:    acc[7:4]  <= ~row_s2;
                    2'd2:    acc[11:8] <= ~row_s2;
                    default: ;
                endcase
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Debounce FSM, evaluated once per completed scan.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = rep;
`endif
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand_n = pos;
                        if (DB == 4'd1) begin
                            accept  = 1'b1;
                            cnt_n   = 4'd0;
                            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = 4'd0;
`endif
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (single && pos == cand) begin
                        if (cnt + 4'd1 >= DB) begin
                            accept  = 1'b1;
                            cnt_n   = 4'd0;
                            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = 4'd0;
`endif
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else if (single) begin
                        cand_n = pos;
                        cnt_n  = 4'd1;
                    end else begin
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (!single) begin
                        if (DB == 4'd1) begin
                            cnt_n   = 4'd0;
                            state_n = IDLE;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (pos == cand) begin
                        if (rep == 4'd15) begin
                            accept = 1'b1;
                            rep_n  = 4'd0;
                        end else begin
                            rep_n = rep + 4'd1;
                        end
                    end else begin
                        rep_n = 4'd0;
                    end
`endif
                end
                default: begin // RELEASE
                    if (!single) begin
                        if (cnt + 4'd1 >= DB) begin
                            cnt_n   = 4'd0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        cnt_n   = 4'd0;
                        state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_n   = 4'd0;
`endif
                    end
                end
            endcase
        end

        // Clear first, then shift, so clr+accept leaves only the new digit.
        data_n = clr ? 16'h0000 : data;
        if (accept) data_n = {data_n[11:0], code};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            data      <= 16'h0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= 4'd0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            data      <= data_n;
            key_valid <= accept;
            if (accept) key_code <= code;
`ifdef KEYPAD_REPEAT_EN
            rep       <= rep_n;
`endif
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// tb_hex_keypad_entry
//   Bench for hex_keypad_entry. An ideal keypad model turns a set of pressed
//   keys into row levels from the driven column. Stimulus is applied in
//   whole scans; a reference model reasons about runs of identical scans
//   and predicts accepted keys and the entry register.
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic [15:0] data;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] pressed;   // bit k = hex key k held down

    int n_vec;
    int n_err;
    int pulse_cnt;

    // reference model state
    logic [3:0]  exp_q[$];
    logic [15:0] exp_data;
    int          exp_pulses;
    bit          m_held;
    logic [3:0]  m_held_key;
    logic [3:0]  m_last_key;
    int          m_same_run;
    int          m_none_run;
    int          m_rep;

    hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .clr       (clr),
        .col       (col),
        .data      (data),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad legend: row r, column c
    function automatic logic [3:0] key_at(input int r, input int c);
        logic [3:0] k;
        case (r * 4 + c)
            0: k = 4'h1;  1: k = 4'h2;  2: k = 4'h3;  3: k = 4'hA;
            4: k = 4'h4;  5: k = 4'h5;  6: k = 4'h6;  7: k = 4'hB;
            8: k = 4'h7;  9: k = 4'h8; 10: k = 4'h9; 11: k = 4'hC;
           12: k = 4'hE; 13: k = 4'h0; 14: k = 4'hF; default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[key_at(r, c)]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: every pulse must match the next predicted key
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("unexpected_pulse", 16'(key_code), 16'hFFFF);
            else                   check("key_code", 16'(key_code), 16'(exp_q.pop_front()));
        end
    end

    function automatic void emit(input logic [3:0] k);
        exp_q.push_back(k);
        exp_data = {exp_data[11:0], k};
        exp_pulses++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_data   = 16'h0000;
        m_held     = 0;
        m_same_run = 0;
        m_none_run = 0;
        m_rep      = 0;
    endfunction

    // One full scan with a fixed set of held keys. Only a lone key counts as
    // a press; nothing and ghosted combinations both count as released.
    function automatic void model_scan(input logic [15:0] keys);
        logic [3:0] k;
        bit         was_releasing;
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = 4'(i);
        if ($countones(keys) == 1) begin
            was_releasing = (m_none_run > 0);
            m_none_run = 0;
            if (m_same_run > 0 && k == m_last_key) m_same_run++;
            else                                   m_same_run = 1;
            m_last_key = k;
            if (!m_held) begin
                if (m_same_run == DB) begin
                    emit(k);
                    m_held     = 1;
                    m_held_key = k;
                    m_rep      = 0;
                end
            end else begin
`ifdef KEYPAD_REPEAT_EN
                if (was_releasing)        m_rep = 0;
                else if (k == m_held_key) begin
                    m_rep++;
                    if (m_rep == 16) begin
                        emit(k);
                        m_rep = 0;
                    end
                end else                  m_rep = 0;
`endif
            end
        end else begin
            m_same_run = 0;
            m_none_run++;
            if (m_held && m_none_run >= DB) m_held = 0;
        end
    endfunction

    // Wait for column 0 to begin a new scan (seen at a negedge).
    task automatic wait_scan_start();
        logic [3:0] prev;
        bit found;
        prev  = col;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (col == 4'b1110 && prev == 4'b0111) found = 1;
            prev = col;
        end
        if (!found) check("scan_start_timeout", 16'h0, 16'h1);
    endtask

    task automatic apply_scans(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) begin
            wait_scan_start();
            pressed = keys;
            model_scan(keys);
        end
    endtask

    task automatic enter_key(input logic [3:0] k, input int hold, input int rel);
        apply_scans(16'h0001 << k, hold);
        apply_scans(16'h0000, rel);
    endtask

    task automatic phase_end(input string tag);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_pulses"}, 16'(pulse_cnt), 16'(exp_pulses));
        check({tag, "_queue"}, 16'(exp_q.size()), 16'h0);
    endtask

    task automatic wait_col3();
        bit found;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (col == 4'b0111) found = 1;
        end
        if (!found) check("col3_timeout", 16'h0, 16'h1);
    endtask

    initial begin
        int base;
        n_vec = 0; n_err = 0; pulse_cnt = 0; exp_pulses = 0;
        pressed = 16'h0000;
        clr     = 1'b0;
        reset   = 1'b1;
        model_reset();

        // reset and scan cadence
        repeat (3) @(negedge clk);
        check("rst_col", 16'(col), 16'h000E);
        check("rst_data", data, 16'h0000);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_code", 16'(key_code), 16'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("dwell_col0", 16'(col), 16'h000E);
        @(negedge clk);
        check("step_col1", 16'(col), 16'h000D);
        repeat (11) @(negedge clk);
        check("last_col3", 16'(col), 16'h0007);
        @(negedge clk);
        check("wrap_col0", 16'(col), 16'h000E);

        // single press of '5'
        base = pulse_cnt;
        enter_key(4'h5, 10, 5);
        phase_end("single");
        check("single_data_k", data, 16'h0005);
        check("single_count", 16'(pulse_cnt - base), 16'd1);
        check("single_code", 16'(key_code), 16'h5);

        // sequence with wrap-around
        base = pulse_cnt;
        enter_key(4'h1, 5, 5);
        enter_key(4'h2, 5, 5);
        enter_key(4'hA, 5, 5);
        enter_key(4'hF, 5, 5);
        phase_end("seq4");
        check("seq4_data_k", data, 16'h12AF);
        check("seq4_count", 16'(pulse_cnt - base), 16'd4);
        enter_key(4'h3, 5, 5);
        phase_end("seq5");
        check("seq5_data_k", data, 16'h2AF3);
        check("seq5_count", 16'(pulse_cnt - base), 16'd5);

        // bounce and ghost rejection
        base = pulse_cnt;
        enter_key(4'h7, 2, 3);
        apply_scans(16'h0006, 8);
        apply_scans(16'h0000, 4);
        phase_end("ghost");
        check("ghost_data_k", data, 16'h2AF3);
        check("ghost_count", 16'(pulse_cnt - base), 16'd0);

        // reset in the middle of a press
        base = pulse_cnt;
        apply_scans(16'h0200, 2);
        repeat (5) @(negedge clk);
        pressed = 16'h0000;
        reset   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("mid_rst_col", 16'(col), 16'h000E);
        check("mid_rst_data", data, 16'h0000);
        check("mid_rst_valid", 16'(key_valid), 16'h0);
        check("mid_rst_code", 16'(key_code), 16'h0);
        reset = 1'b0;
        apply_scans(16'h0000, 2);
        check("mid_rst_count", 16'(pulse_cnt - base), 16'd0);
        enter_key(4'hD, 5, 5);
        phase_end("repress");
        check("repress_data_k", data, 16'h000D);

        // clear coinciding with the accept of 'E'
        apply_scans(16'h4000, 2);
        wait_scan_start();
        pressed = 16'h4000;
        model_scan(16'h4000);
        exp_data = 16'h000E;
        wait_col3();
        repeat (3) @(negedge clk);
        check("pre_accept_valid", 16'(key_valid), 16'h0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("accept_latency", 16'(key_valid), 16'h1);
        check("clr_accept_data", data, 16'h000E);
        apply_scans(16'h4000, 2);
        apply_scans(16'h0000, 5);
        phase_end("clr");

        // randomized press / bounce / ghost traffic
        for (int it = 0; it < 40; it++) begin
            logic [15:0] keys;
            int kind;
            int a, b;
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            case (kind)
                0:       keys = 16'h0000;
                1:       keys = 16'h0001 << a;
                default: keys = (16'h0001 << a) | (16'h0001 << b);
            endcase
            apply_scans(keys, $urandom_range(1, 6));
        end
        apply_scans(16'h0000, 5);
        phase_end("random");

`ifdef KEYPAD_REPEAT_EN
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_data = 16'h0000;
        base = pulse_cnt;
        enter_key(4'hB, 40, 5);
        phase_end("repeat");
        check("repeat_data_k", data, 16'h0BBB);
        check("repeat_count", 16'(pulse_cnt - base), 16'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
